// File: rtl/arb_mux_pkg.sv
// Shared encodings and helpers for the arbitrated N:1 output selector.
package arb_mux_pkg;

  // Arbitration modes selectable through the MODE parameter.
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Ceiling log2 with a floor of 1 so a select field never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/arb_mux_rr_pick.sv
// Rotated priority search: first set request at or after start, wrapping at N-1.
module rr_pick
  import arb_mux_pkg::*;
#(
  parameter int N     = 8,
  parameter int SEL_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

  logic [2*N-1:0] req2;
  logic [N-1:0]   rot;
  logic           found;
  int             sum;

  // Duplicate the request vector so a plain part-select yields the rotated view.
  always_comb begin
    req2    = {req, req};
    rot     = req2[start +: N];
    any     = |req;
    found   = 1'b0;
    sum     = 0;
    gnt_idx = '0;
    for (int j = 0; j < N; j++) begin
      if (rot[j] && !found) begin
        found = 1'b1;
        sum   = int'(start) + j;
        if (sum >= N) sum = sum - N;
        gnt_idx = SEL_W'(sum);
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// Registered N:1 selector with valid/ready handshake and built-in arbitration.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int N     = 8,
  parameter int WIDTH = 8,
  parameter int MODE  = ARB_RR,
  parameter int SEL_W = clog2_min1(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  input  logic               out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic [SEL_W-1:0] last_q, last_d;

  logic             load;
  logic             grant;
  logic             any;
  logic [SEL_W-1:0] start;
  logic [SEL_W-1:0] gnt_idx;
  logic [WIDTH-1:0] ch_data [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  // Search origin: fixed priority always starts at 0; round robin starts just past the last winner.
  always_comb begin
    start = '0;
    if (MODE == ARB_RR && last_q != SEL_W'(N-1)) start = last_q + SEL_W'(1);
  end

  rr_pick #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_pick (
    .req     (in_valid),
    .start   (start),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // Load when the output stage is empty or draining; ready is held low during reset.
  always_comb begin
    load     = !out_valid_q || out_ready;
    grant    = rst_n && load && any;
    in_ready = '0;
    if (grant) in_ready[gnt_idx] = 1'b1;
  end

  // Next values of the output stage and the round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    last_d      = last_q;
    if (load) begin
      out_valid_d = any;
      if (any) begin
        out_data_d = ch_data[gnt_idx];
        out_sel_d  = gnt_idx;
        last_d     = gnt_idx;
      end
    end
  end

  // Output register and pointer; reset discards any buffered beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      last_q      <= SEL_W'(N-1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: one fixed-priority and one round-robin instance share stimulus.
module tb_arb_mux;

  localparam int N = 8;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic           out_ready;

  logic [N-1:0] rdy0, rdy1;
  logic         ov0, ov1;
  logic [W-1:0] od0, od1;
  logic [2:0]   os0, os1;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  arb_mux #(.N(N), .WIDTH(W), .MODE(0)) u_fix (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy0), .out_valid(ov0), .out_data(od0), .out_sel(os0),
    .out_ready(out_ready)
  );

  arb_mux #(.N(N), .WIDTH(W), .MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy1), .out_valid(ov1), .out_data(od1), .out_sel(os1),
    .out_ready(out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model, index 0 = fixed priority, 1 = round robin.
  bit       mv [2] = '{0, 0};
  int       md [2] = '{0, 0};
  int       ms [2] = '{0, 0};
  int       ml [2] = '{N-1, N-1};
  bit       nv [2] = '{0, 0};
  int       nd [2] = '{0, 0};
  int       ns [2] = '{0, 0};
  int       nl [2] = '{N-1, N-1};

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      bit   ld;
      int   g;
      int   idx;
      logic [N-1:0] er;
      ld = !mv[m] || out_ready;
      g  = -1;
      if (rst_n && ld) begin
        for (int k = 1; k <= N; k++) begin
          idx = (m == 0) ? (k - 1) : ((ml[m] + k) % N);
          if (g < 0 && in_valid[idx]) g = idx;
        end
      end
      er = (g >= 0) ? (N'(1) << g) : '0;
      if (chk_en) begin
        if (m == 0) begin
          chk("fix in_ready", rdy0, er);
          chk("fix out_valid", ov0, mv[m]);
          chk("fix out_data", od0, md[m]);
          chk("fix out_sel", os0, ms[m]);
        end else begin
          chk("rr in_ready", rdy1, er);
          chk("rr out_valid", ov1, mv[m]);
          chk("rr out_data", od1, md[m]);
          chk("rr out_sel", os1, ms[m]);
        end
      end
      nv[m] = mv[m]; nd[m] = md[m]; ns[m] = ms[m]; nl[m] = ml[m];
      if (!rst_n) begin
        nv[m] = 0; nd[m] = 0; ns[m] = 0; nl[m] = N-1;
      end else if (ld) begin
        nv[m] = (g >= 0);
        if (g >= 0) begin
          nd[m] = in_data[g*W +: W];
          ns[m] = g;
          nl[m] = g;
        end
      end
    end
  end

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      mv[m] = nv[m]; md[m] = nd[m]; ms[m] = ns[m]; ml[m] = nl[m];
    end
  end

  task automatic set_data_inc();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(8'h10 + i);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = '1;
    out_ready = 1'b1;
    set_data_inc();
    tick();
    chk_en = 1'b1;

    // Reset held with every channel requesting.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("reset out_valid", ov1, 0);
      chk("reset out_data", od1, 8'h00);
      chk("reset out_sel", os1, 0);
      chk("reset in_ready", rdy1, 8'h00);
      tick();
    end

    // Round-robin fairness: 0..7,0,1 with no bubbles.
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      @(negedge clk);
      chk("rr seq out_sel", os1, k % 8);
      chk("rr seq out_data", od1, 8'h10 + (k % 8));
      chk("rr seq out_valid", ov1, 1);
    end
    tick();

    // Fixed priority with channels 2 and 3 requesting.
    in_valid = 8'h0C;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      chk("fix out_sel=2", os0, 2);
      chk("fix in_ready=04", rdy0, 8'h04);
    end
    tick();

    // Sparse round robin alternates between the two end channels.
    in_valid = 8'h81;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      chk("sparse out_sel", os1, (k % 2 == 1) ? 7 : 0);
    end
    tick();

    // Backpressure on the beat from channel 3.
    in_valid = 8'hFF;
    do_reset();
    repeat (4) tick();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp out_valid", ov1, 1);
      chk("bp out_data", od1, 8'h13);
      chk("bp in_ready", rdy1, 8'h00);
      tick();
    end
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("bp resume out_sel", os1, 4);
    chk("bp resume out_data", od1, 8'h14);
    tick();

    // Idle drain after a single beat from channel 5.
    in_valid = 8'h20;
    do_reset();
    tick();
    in_valid = 8'h00;
    @(negedge clk);
    chk("drain beat valid", ov1, 1);
    chk("drain beat sel", os1, 5);
    tick();
    @(negedge clk);
    chk("drain out_valid", ov1, 0);
    chk("drain out_sel hold", os1, 5);
    tick();

    // Randomised traffic with occasional reset, checked by the model every cycle.
    for (int k = 0; k < 3000; k++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: in_valid = '0;
        1: in_valid = N'($urandom);
        2: in_valid = N'(1) << $urandom_range(0, N-1);
        default: in_valid = N'($urandom) | N'($urandom);
      endcase
      in_data = {$urandom, $urandom};
      tick();
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
